// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the ID->EX->MEM->WB control pipeline.
package pipe_pkg;

  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 2;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  // Forwarding select encodings seen by the EX operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic               reg_dest;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  // Full stage register contents; dest is already resolved from RegDest.
  typedef struct packed {
    ex_ctrl_t          ctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
  } ex_stage_t;

  typedef struct packed {
    mem_ctrl_t         ctrl;
    logic [REG_AW-1:0] dest;
  } mem_stage_t;

  typedef struct packed {
    wb_ctrl_t          ctrl;
    logic [REG_AW-1:0] dest;
  } wb_stage_t;

  // Bubbles: no control asserted and register fields zero, so they never
  // write, never touch memory and never match hazard/forwarding compares.
  localparam ex_ctrl_t   EX_BUBBLE        = '0;
  localparam mem_ctrl_t  MEM_BUBBLE       = '0;
  localparam wb_ctrl_t   WB_BUBBLE        = '0;
  localparam ex_stage_t  EX_STAGE_BUBBLE  = '0;
  localparam mem_stage_t MEM_STAGE_BUBBLE = '0;
  localparam wb_stage_t  WB_STAGE_BUBBLE  = '0;

  // Strip the EX-only fields when an instruction moves into MEM.
  function automatic mem_ctrl_t to_mem(input ex_ctrl_t c);
    mem_ctrl_t m;
    m.branch     = c.branch;
    m.mem_read   = c.mem_read;
    m.mem_write  = c.mem_write;
    m.mem_to_reg = c.mem_to_reg;
    m.reg_write  = c.reg_write;
    return m;
  endfunction

  // Strip the MEM-only fields when an instruction moves into WB.
  function automatic wb_ctrl_t to_wb(input mem_ctrl_t c);
    wb_ctrl_t w;
    w.mem_to_reg = c.mem_to_reg;
    w.reg_write  = c.reg_write;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle between the decoder/hazard environment and the control pipeline.
interface ctrl_pipe_if;
  import pipe_pkg::*;

  logic               hold;
  logic               id_RegDest;
  logic               id_Branch;
  logic               id_MemRead;
  logic               id_MemToReg;
  logic               id_MemWrite;
  logic               id_ALUSrc;
  logic               id_RegWrite;
  logic [ALUOP_W-1:0] id_ALUOp;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               branch_taken;

  logic               stall;
  logic               ifid_flush;
  logic               ex_RegDest;
  logic               ex_ALUSrc;
  logic [ALUOP_W-1:0] ex_ALUOp;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_dest;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic               mem_Branch;
  logic               mem_MemRead;
  logic               mem_MemWrite;
  logic [REG_AW-1:0]  mem_dest;
  logic               wb_MemToReg;
  logic               wb_RegWrite;
  logic [REG_AW-1:0]  wb_dest;

  modport master (
    output hold, id_RegDest, id_Branch, id_MemRead, id_MemToReg, id_MemWrite,
           id_ALUSrc, id_RegWrite, id_ALUOp, id_rs, id_rt, id_rd, branch_taken,
    input  stall, ifid_flush, ex_RegDest, ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt,
           ex_dest, fwd_a, fwd_b, mem_Branch, mem_MemRead, mem_MemWrite,
           mem_dest, wb_MemToReg, wb_RegWrite, wb_dest
  );

  modport slave (
    input  hold, id_RegDest, id_Branch, id_MemRead, id_MemToReg, id_MemWrite,
           id_ALUSrc, id_RegWrite, id_ALUOp, id_rs, id_rt, id_rd, branch_taken,
    output stall, ifid_flush, ex_RegDest, ex_ALUSrc, ex_ALUOp, ex_rs, ex_rt,
           ex_dest, fwd_a, fwd_b, mem_Branch, mem_MemRead, mem_MemWrite,
           mem_dest, wb_MemToReg, wb_RegWrite, wb_dest
  );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// Operand forwarding compare for one EX source register.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  output logic [1:0]        sel_o
);

  // EX/MEM result is younger, so it wins over MEM/WB; $zero never forwards.
  always_comb begin
    sel_o = FWD_RF;
    if (mem_we_i && (mem_dest_i != REG_ZERO) && (mem_dest_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_we_i && (wb_dest_i != REG_ZERO) && (wb_dest_i == src_i)) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoded control through EX/MEM/WB, inserts
// load-use and branch-flush bubbles, and produces EX forwarding selects.
module ctrl_pipe
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave pif
);

  ex_stage_t  ex_d,  ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d,  wb_q;

  logic       load_use_s;
  logic       stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // Load in EX whose target is read by the instruction in ID; flush overrides.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_q.ctrl.mem_read && (ex_q.dest != REG_ZERO) &&
        ((ex_q.dest == pif.id_rs) || (ex_q.dest == pif.id_rt))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
    stall_s = load_use_s & ~pif.branch_taken;
  end

  // Next-state of the three stage registers, including bubble insertion.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!pif.hold) begin
      wb_d.ctrl = to_wb(mem_q.ctrl);
      wb_d.dest = mem_q.dest;

      if (pif.branch_taken) begin
        mem_d = MEM_STAGE_BUBBLE;
      end else begin
        mem_d.ctrl = to_mem(ex_q.ctrl);
        mem_d.dest = ex_q.dest;
      end

      if (pif.branch_taken || stall_s) begin
        ex_d = EX_STAGE_BUBBLE;
      end else begin
        ex_d.ctrl.reg_dest   = pif.id_RegDest;
        ex_d.ctrl.alu_src    = pif.id_ALUSrc;
        ex_d.ctrl.alu_op     = pif.id_ALUOp;
        ex_d.ctrl.branch     = pif.id_Branch;
        ex_d.ctrl.mem_read   = pif.id_MemRead;
        ex_d.ctrl.mem_write  = pif.id_MemWrite;
        ex_d.ctrl.mem_to_reg = pif.id_MemToReg;
        ex_d.ctrl.reg_write  = pif.id_RegWrite;
        ex_d.rs              = pif.id_rs;
        ex_d.rt              = pif.id_rt;
        ex_d.dest            = pif.id_RegDest ? pif.id_rd : pif.id_rt;
      end
    end else begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end
  end

  // Stage registers with asynchronous clear to bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_STAGE_BUBBLE;
      mem_q <= MEM_STAGE_BUBBLE;
      wb_q  <= WB_STAGE_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_unit u_fwd_a (
    .src_i      (ex_q.rs),
    .mem_we_i   (mem_q.ctrl.reg_write),
    .mem_dest_i (mem_q.dest),
    .wb_we_i    (wb_q.ctrl.reg_write),
    .wb_dest_i  (wb_q.dest),
    .sel_o      (fwd_a_s)
  );

  fwd_unit u_fwd_b (
    .src_i      (ex_q.rt),
    .mem_we_i   (mem_q.ctrl.reg_write),
    .mem_dest_i (mem_q.dest),
    .wb_we_i    (wb_q.ctrl.reg_write),
    .wb_dest_i  (wb_q.dest),
    .sel_o      (fwd_b_s)
  );

  assign pif.stall        = stall_s;
  assign pif.ifid_flush   = pif.branch_taken;
  assign pif.ex_RegDest   = ex_q.ctrl.reg_dest;
  assign pif.ex_ALUSrc    = ex_q.ctrl.alu_src;
  assign pif.ex_ALUOp     = ex_q.ctrl.alu_op;
  assign pif.ex_rs        = ex_q.rs;
  assign pif.ex_rt        = ex_q.rt;
  assign pif.ex_dest      = ex_q.dest;
  assign pif.fwd_a        = fwd_a_s;
  assign pif.fwd_b        = fwd_b_s;
  assign pif.mem_Branch   = mem_q.ctrl.branch;
  assign pif.mem_MemRead  = mem_q.ctrl.mem_read;
  assign pif.mem_MemWrite = mem_q.ctrl.mem_write;
  assign pif.mem_dest     = mem_q.dest;
  assign pif.wb_MemToReg  = wb_q.ctrl.mem_to_reg;
  assign pif.wb_RegWrite  = wb_q.ctrl.reg_write;
  assign pif.wb_dest      = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus a randomized
// run compared against an instruction-level pipeline model.
module tb_ctrl_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ctrl_pipe_if pif ();

  ctrl_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every DUT output flattened, in a fixed order, for whole-state compares.
  logic [39:0] dut_vec;
  assign dut_vec = {pif.stall, pif.ifid_flush, pif.ex_RegDest, pif.ex_ALUSrc,
                    pif.ex_ALUOp, pif.ex_rs, pif.ex_rt, pif.ex_dest,
                    pif.fwd_a, pif.fwd_b, pif.mem_Branch, pif.mem_MemRead,
                    pif.mem_MemWrite, pif.mem_dest, pif.wb_MemToReg,
                    pif.wb_RegWrite, pif.wb_dest};

  // Reference model: each stage holds a whole instruction record.
  typedef struct packed {
    logic       reg_dest;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (m_mem.reg_write && m_mem.dest != 5'd0 && m_mem.dest == r) return 2'b10;
    if (m_wb.reg_write && m_wb.dest != 5'd0 && m_wb.dest == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    return m_ex.mem_read && (m_ex.dest != 5'd0) &&
           (m_ex.dest == pif.id_rs || m_ex.dest == pif.id_rt) &&
           !pif.branch_taken;
  endfunction

  function automatic logic [39:0] model_vec();
    return {m_stall(), pif.branch_taken, m_ex.reg_dest, m_ex.alu_src,
            m_ex.alu_op, m_ex.rs, m_ex.rt, m_ex.dest,
            m_fwd(m_ex.rs), m_fwd(m_ex.rt), m_mem.branch, m_mem.mem_read,
            m_mem.mem_write, m_mem.dest, m_wb.mem_to_reg, m_wb.reg_write,
            m_wb.dest};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    instr_t id_i;
    logic   st;
    if (pif.hold) return;
    id_i.reg_dest   = pif.id_RegDest;
    id_i.alu_src    = pif.id_ALUSrc;
    id_i.alu_op     = pif.id_ALUOp;
    id_i.branch     = pif.id_Branch;
    id_i.mem_read   = pif.id_MemRead;
    id_i.mem_write  = pif.id_MemWrite;
    id_i.mem_to_reg = pif.id_MemToReg;
    id_i.reg_write  = pif.id_RegWrite;
    id_i.rs         = pif.id_rs;
    id_i.rt         = pif.id_rt;
    id_i.dest       = pif.id_RegDest ? pif.id_rd : pif.id_rt;
    st    = m_stall();
    m_wb  = m_mem;
    m_mem = pif.branch_taken ? instr_t'(0) : m_ex;
    m_ex  = (pif.branch_taken || st) ? instr_t'(0) : id_i;
  endtask

  task automatic set_id(input logic rdst, input logic alusrc, input logic [1:0] aluop,
                        input logic br, input logic mr, input logic mw,
                        input logic m2r, input logic rw,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    pif.id_RegDest  = rdst;
    pif.id_ALUSrc   = alusrc;
    pif.id_ALUOp    = aluop;
    pif.id_Branch   = br;
    pif.id_MemRead  = mr;
    pif.id_MemWrite = mw;
    pif.id_MemToReg = m2r;
    pif.id_RegWrite = rw;
    pif.id_rs       = rs;
    pif.id_rt       = rt;
    pif.id_rd       = rd;
  endtask

  task automatic set_nop();
    set_id(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    pif.hold = 1'b0;
    pif.branch_taken = 1'b0;
    set_nop();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pif.hold = 1'b0;
    pif.branch_taken = 1'b0;
    set_nop();
    #3;
    total++;
    if (dut_vec !== 40'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", dut_vec, 40'd0);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_alu_seq();
    drain();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                        5'd1, 5'd2, 5'(8 + i));
      else set_nop();
      #1;
      total++;
      if ({pif.stall, pif.fwd_a, pif.fwd_b} !== 5'b0) begin
        bad++;
        $display("FAIL alu_seq_nohaz cyc%0d: got %b want 00000", i,
                 {pif.stall, pif.fwd_a, pif.fwd_b});
      end
      if (i >= 3) begin
        total++;
        if ({pif.wb_RegWrite, pif.wb_dest} !== {1'b1, 5'(8 + i - 3)}) begin
          bad++;
          $display("FAIL alu_seq_wb cyc%0d: got %b/%0d want 1/%0d", i,
                   pif.wb_RegWrite, pif.wb_dest, 8 + i - 3);
        end
      end
      step();
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd8, 5'd0);
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd2, 5'd3);
    #1;
    total++;
    if (pif.stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall: got %b want 1", pif.stall);
    end
    step();
    total++;
    if ({pif.stall, pif.ex_dest, pif.ex_rs, pif.mem_MemRead, pif.mem_dest} !==
        {1'b0, 5'd0, 5'd0, 1'b1, 5'd8}) begin
      bad++;
      $display("FAIL load_use_bubble: got stall=%b exd=%0d exrs=%0d mr=%b md=%0d want 0/0/0/1/8",
               pif.stall, pif.ex_dest, pif.ex_rs, pif.mem_MemRead, pif.mem_dest);
    end
    step();
    set_nop();
    #1;
    total++;
    if ({pif.ex_rs, pif.ex_dest, pif.fwd_a, pif.fwd_b} !== {5'd8, 5'd3, 2'b01, 2'b00}) begin
      bad++;
      $display("FAIL load_use_fwd: got rs=%0d dest=%0d fa=%b fb=%b want 8/3/01/00",
               pif.ex_rs, pif.ex_dest, pif.fwd_a, pif.fwd_b);
    end
  endtask

  task automatic test_fwd_priority();
    drain();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5);
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd1, 5'd5);
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd6);
    step();
    set_nop();
    #1;
    total++;
    if ({pif.fwd_a, pif.fwd_b} !== 4'b1010) begin
      bad++;
      $display("FAIL fwd_priority: got %b%b want 1010", pif.fwd_a, pif.fwd_b);
    end
    step();
    total++;
    if ({pif.fwd_a, pif.fwd_b} !== 4'b0000) begin
      bad++;
      $display("FAIL fwd_after_nop: got %b%b want 0000", pif.fwd_a, pif.fwd_b);
    end
  endtask

  task automatic test_reg0();
    drain();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0);
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3);
    step();
    set_id(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0);
    #1;
    total++;
    if ({pif.fwd_a, pif.fwd_b, pif.stall} !== 5'b00000) begin
      bad++;
      $display("FAIL reg0_fwd: got %b%b stall=%b want 0000 0", pif.fwd_a, pif.fwd_b, pif.stall);
    end
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4);
    #1;
    total++;
    if (pif.stall !== 1'b0) begin
      bad++;
      $display("FAIL reg0_load_stall: got %b want 0", pif.stall);
    end
  endtask

  task automatic test_flush();
    drain();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7);
    step();
    set_id(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd8, 5'd0);
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd2, 5'd3);
    pif.branch_taken = 1'b1;
    #1;
    total++;
    if ({pif.ifid_flush, pif.stall} !== 2'b10) begin
      bad++;
      $display("FAIL flush_over_stall: got flush=%b stall=%b want 1 0", pif.ifid_flush, pif.stall);
    end
    step();
    pif.branch_taken = 1'b0;
    set_nop();
    #1;
    total++;
    if ({pif.ex_dest, pif.ex_rs, pif.mem_MemRead, pif.mem_MemWrite, pif.mem_dest,
         pif.wb_RegWrite, pif.wb_dest} !== {5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7}) begin
      bad++;
      $display("FAIL flush_bubbles: got exd=%0d exrs=%0d mr=%b mw=%b md=%0d wbw=%b wbd=%0d want 0/0/0/0/0/1/7",
               pif.ex_dest, pif.ex_rs, pif.mem_MemRead, pif.mem_MemWrite, pif.mem_dest,
               pif.wb_RegWrite, pif.wb_dest);
    end
    step();
    total++;
    if ({pif.wb_RegWrite, pif.mem_MemWrite} !== 2'b00) begin
      bad++;
      $display("FAIL flush_wb_squashed: got wbw=%b mw=%b want 0 0", pif.wb_RegWrite, pif.mem_MemWrite);
    end
  endtask

  task automatic test_hold_reset();
    drain();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    step();
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd4);
    step();
    set_id(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd6);
    pif.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({pif.ex_rs, pif.ex_dest, pif.mem_dest, pif.wb_dest, pif.fwd_a, pif.fwd_b, pif.stall} !==
          {5'd3, 5'd4, 5'd3, 5'd0, 2'b10, 2'b10, 1'b0}) begin
        bad++;
        $display("FAIL hold_frozen cyc%0d: got rs=%0d exd=%0d md=%0d wd=%0d fa=%b fb=%b st=%b", i,
                 pif.ex_rs, pif.ex_dest, pif.mem_dest, pif.wb_dest, pif.fwd_a, pif.fwd_b, pif.stall);
      end
      step();
    end
    rst_n = 1'b0;
    set_nop();
    #1;
    total++;
    if (dut_vec !== 40'd0) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", dut_vec, 40'd0);
    end
    #1;
    rst_n = 1'b1;
    pif.hold = 1'b0;
    set_id(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9);
    step();
    total++;
    if ({pif.ex_RegDest, pif.ex_dest, pif.mem_dest} !== {1'b1, 5'd9, 5'd0}) begin
      bad++;
      $display("FAIL post_reset_load: got rd=%b exd=%0d md=%0d want 1/9/0",
               pif.ex_RegDest, pif.ex_dest, pif.mem_dest);
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    drain();
    m_ex = '0; m_mem = '0; m_wb = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      set_id(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      pif.branch_taken = ($urandom_range(0, 7) == 0);
      pif.hold         = ($urandom_range(0, 7) == 0);
      #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL random cyc%0d: got %h want %h", c, dut_vec, model_vec());
      end
      if (c == 300) begin
        rst_n = 1'b0;
        #1;
        m_ex = '0; m_mem = '0; m_wb = '0;
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("FAIL random_reset: got %h want %h", dut_vec, model_vec());
        end
        #1;
        rst_n = 1'b1;
      end
      model_edge();
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_seq();
    test_load_use();
    test_fwd_priority();
    test_reg0();
    test_flush();
    test_hold_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
